fetch_decode: RTL
=================

# fetch_decode

Instruction fetch and decode stage placed directly upstream of `execute`. Reads the two opcode bytes at the current PC from program memory, assembles the big-endian 16-bit opcode, decodes it into the 7-bit operation index and operand fields that `execute` consumes, and presents them under a valid/ready handshake. Once the instruction has been handed over, the stage waits for `execute` to report completion before it fetches again, because `execute` may rewrite PC.

## Interface
- `ADDR_W`, default 12: program memory address width; CHIP-8 space is 4 KiB.
- `ILLEGAL_OP`, default 7'd127: decode index for unrecognised opcodes.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `i_pc_data`  in  16  current PC from the PC register; only `[ADDR_W-1:0]` is used.
- `i_halt`  in  1  when high in IDLE, the stage holds and does not start a fetch.
- `o_mem_r_en`  out  1  memory read strobe.
- `o_mem_r_addr`  out  ADDR_W  memory read address.
- `i_mem_r_data`  in  8  read data, valid exactly 1 cycle after `o_mem_r_en`.
- `o_valid`  out  1  decoded instruction available.
- `i_ready`  in  1  `execute` accepts the instruction.
- `i_exec_done`  in  1  one-cycle pulse; `execute` has retired the instruction and PC is updated.
- `o_decode`  out  7  operation index, 0–34 or `ILLEGAL_OP`.
- `o_opcode`  out  16  raw opcode.
- `o_vx_addr`  out  4  opcode[11:8].
- `o_vy_addr`  out  4  opcode[7:4].
- `o_byte_kk`  out  8  opcode[7:0].
- `o_nibble_n`  out  4  opcode[3:0].
- `o_mem_addr`  out  12  nnn, opcode[11:0].

## Operation
- FSM states: IDLE, RD_HI, RD_LO, CAPTURE, ISSUE, WAIT_EXEC.
- IDLE → RD_HI when `i_halt`=0; otherwise stay in IDLE.
- RD_HI:
  - `o_mem_r_en`=1, `o_mem_r_addr`=pc.
  - Go to RD_LO.
- RD_LO:
  - `o_mem_r_en`=1, `o_mem_r_addr`=pc+1, modulo 2^ADDR_W, so 0xFFF wraps to 0x000.
  - Latch the high byte from `i_mem_r_data`.
  - Go to CAPTURE.
- CAPTURE:
  - Latch the low byte.
  - Decode {hi, lo} and register all output fields.
  - Go to ISSUE.
- PC is sampled in RD_HI only; later changes to `i_pc_data` are ignored until the next fetch.
- ISSUE:
  - `o_valid`=1, with all fields held stable.
  - On `i_ready`=1 the instruction is transferred.
  - After transfer, go to RD_HI if `i_exec_done`=1 in the same cycle, else go to WAIT_EXEC.
- WAIT_EXEC:
  - `o_valid`=0.
  - On `i_exec_done`: go to IDLE if `i_halt`, else RD_HI.
- `i_exec_done` outside ISSUE/WAIT_EXEC is ignored.
- `i_ready` outside ISSUE is ignored.
- Decode map, in index order:
  - 0 CLS 00E0; 1 RET 00EE; 2 SYS 0nnn (any other 0xxx).
  - 3 JP 1nnn; 4 CALL 2nnn; 5 SE 3xkk; 6 SNE 4xkk; 7 SE 5xy0.
  - 8 LD 6xkk; 9 ADD 7xkk.
  - 10–18: 8xy0 through 8xy7, then 8xyE.
  - 19 SNE 9xy0; 20 LD I Annn; 21 JP V0 Bnnn; 22 RND Cxkk; 23 DRW Dxyn.
  - 24 SKP Ex9E; 25 SKNP ExA1.
  - 26–34: Fx07, Fx0A, Fx15, Fx18, Fx1E, Fx29, Fx33, Fx55, Fx65.
  - Anything else, e.g. 5xy1, 8xy8, 9xy1, ExFF, Fx00, decodes to `ILLEGAL_OP`. It is still issued normally; `execute` decides the consequence.

## Timing
- Reset: state=IDLE, and every output is 0 (`o_valid`, `o_mem_r_en`, `o_mem_r_addr`, all decode fields, `o_opcode`).
- Reset mid-operation discards any in-flight fetch or held instruction on the next edge.
- From leaving IDLE to `o_valid`=1 is 4 cycles: RD_HI at T, RD_LO at T+1, CAPTURE at T+2, ISSUE at T+3.
- Back-to-back throughput with `i_ready` and `i_exec_done` tied high: one instruction per 4 cycles.
- Output fields change only on the CAPTURE→ISSUE edge and on reset.
- `o_mem_r_en` is high only in RD_HI and RD_LO.

## Structure
- Shared include `chip8_defs.vh` holds:
  - the 35 operation-index constants plus `ILLEGAL_OP`, shared with `execute`;
  - the state encodings.
- Sub-module `opcode_decoder`: purely combinational, 16-bit opcode in, 7-bit index out. Kept separate so it can be unit-tested exhaustively.

## Test plan
- Reset release with `i_halt`=0, pc=0x200, memory [0x200]=0x6A, [0x201]=0x42:
  - reads at 0x200 then 0x201;
  - `o_valid` rises at T+3;
  - `o_decode`=8, `o_vx_addr`=0xA, `o_byte_kk`=0x42.
- Hold `i_ready`=0 for 5 cycles on 0x8125:
  - `o_valid` and fields stay stable (`o_decode`=15);
  - no memory reads occur;
  - transfer happens on the first ready cycle.
- pc=0xFFF, [0xFFF]=0x00, [0x000]=0xEE:
  - second read address is 0x000;
  - `o_decode`=1, `o_opcode`=0x00EE.
- Opcodes 0x5AB1, 0xE0FF, 0xF000 each yield `o_decode`=127.
- Exhaustive sweep of all 65536 opcodes through `opcode_decoder` against a reference model.
- `i_ready` and `i_exec_done` asserted together in ISSUE:
  - the next RD_HI follows immediately;
  - `i_exec_done` pulse injected in RD_LO is ignored.
- `rst` asserted in RD_LO:
  - next cycle all outputs are 0;
  - refetch starts from the new pc after `rst` drops.
- `i_halt`=1 with `i_exec_done` in WAIT_EXEC: FSM parks in IDLE and issues no reads until `i_halt` drops.

Source files
------------

// File: rtl/fetch_decode_pkg.sv
// fetch_decode_pkg: CHIP-8 operation indices and fetch FSM state encoding shared by fetch, decode and execute.
package fetch_decode_pkg;

   typedef enum logic [2:0] {IDLE, RD_HI, RD_LO, CAPTURE, ISSUE, WAIT_EXEC} state_t;

   localparam logic [6:0] OP_CLS       = 7'd0;
   localparam logic [6:0] OP_RET       = 7'd1;
   localparam logic [6:0] OP_SYS       = 7'd2;
   localparam logic [6:0] OP_JP        = 7'd3;
   localparam logic [6:0] OP_CALL      = 7'd4;
   localparam logic [6:0] OP_SE_VX_KK  = 7'd5;
   localparam logic [6:0] OP_SNE_VX_KK = 7'd6;
   localparam logic [6:0] OP_SE_VX_VY  = 7'd7;
   localparam logic [6:0] OP_LD_VX_KK  = 7'd8;
   localparam logic [6:0] OP_ADD_VX_KK = 7'd9;
   localparam logic [6:0] OP_LD_VX_VY  = 7'd10;
   localparam logic [6:0] OP_OR        = 7'd11;
   localparam logic [6:0] OP_AND       = 7'd12;
   localparam logic [6:0] OP_XOR       = 7'd13;
   localparam logic [6:0] OP_ADD_VX_VY = 7'd14;
   localparam logic [6:0] OP_SUB       = 7'd15;
   localparam logic [6:0] OP_SHR       = 7'd16;
   localparam logic [6:0] OP_SUBN      = 7'd17;
   localparam logic [6:0] OP_SHL       = 7'd18;
   localparam logic [6:0] OP_SNE_VX_VY = 7'd19;
   localparam logic [6:0] OP_LD_I      = 7'd20;
   localparam logic [6:0] OP_JP_V0     = 7'd21;
   localparam logic [6:0] OP_RND       = 7'd22;
   localparam logic [6:0] OP_DRW       = 7'd23;
   localparam logic [6:0] OP_SKP       = 7'd24;
   localparam logic [6:0] OP_SKNP      = 7'd25;
   localparam logic [6:0] OP_LD_VX_DT  = 7'd26;
   localparam logic [6:0] OP_LD_VX_K   = 7'd27;
   localparam logic [6:0] OP_LD_DT_VX  = 7'd28;
   localparam logic [6:0] OP_LD_ST_VX  = 7'd29;
   localparam logic [6:0] OP_ADD_I_VX  = 7'd30;
   localparam logic [6:0] OP_LD_F_VX   = 7'd31;
   localparam logic [6:0] OP_LD_B_VX   = 7'd32;
   localparam logic [6:0] OP_LD_MI_VX  = 7'd33;
   localparam logic [6:0] OP_LD_VX_MI  = 7'd34;
   localparam logic [6:0] OP_ILLEGAL   = 7'd127;

endpackage

// File: rtl/fetch_decode_decoder.sv
// opcode_decoder: combinational CHIP-8 opcode to operation index map.
module opcode_decoder
   import fetch_decode_pkg::*;
#(
   parameter logic [6:0] ILLEGAL_OP = OP_ILLEGAL
) (
   input  logic [15:0] opcode,
   output logic [6:0]  decode
);

   logic [3:0] n;
   logic [7:0] kk;

   assign n  = opcode[3:0];
   assign kk = opcode[7:0];

   always_comb begin
      decode = ILLEGAL_OP;
      case (opcode[15:12])
         4'h0: decode = opcode == 16'h00E0 ? OP_CLS : opcode == 16'h00EE ? OP_RET : OP_SYS;
         4'h1: decode = OP_JP;
         4'h2: decode = OP_CALL;
         4'h3: decode = OP_SE_VX_KK;
         4'h4: decode = OP_SNE_VX_KK;
         4'h5: decode = n == 4'h0 ? OP_SE_VX_VY : ILLEGAL_OP;
         4'h6: decode = OP_LD_VX_KK;
         4'h7: decode = OP_ADD_VX_KK;
         4'h8: decode = !n[3] ? OP_LD_VX_VY + {3'b000, n} : n == 4'hE ? OP_SHL : ILLEGAL_OP;
         4'h9: decode = n == 4'h0 ? OP_SNE_VX_VY : ILLEGAL_OP;
         4'hA: decode = OP_LD_I;
         4'hB: decode = OP_JP_V0;
         4'hC: decode = OP_RND;
         4'hD: decode = OP_DRW;
         4'hE: decode = kk == 8'h9E ? OP_SKP : kk == 8'hA1 ? OP_SKNP : ILLEGAL_OP;
         default:
            case (kk)
               8'h07:   decode = OP_LD_VX_DT;
               8'h0A:   decode = OP_LD_VX_K;
               8'h15:   decode = OP_LD_DT_VX;
               8'h18:   decode = OP_LD_ST_VX;
               8'h1E:   decode = OP_ADD_I_VX;
               8'h29:   decode = OP_LD_F_VX;
               8'h33:   decode = OP_LD_B_VX;
               8'h55:   decode = OP_LD_MI_VX;
               8'h65:   decode = OP_LD_VX_MI;
               default: decode = ILLEGAL_OP;
            endcase
      endcase
   end

endmodule

// File: rtl/fetch_decode.sv
// fetch_decode: reads two opcode bytes at PC, decodes them and issues to execute,
// then waits for execute to retire the instruction since it may rewrite PC.
module fetch_decode
   import fetch_decode_pkg::*;
#(
   parameter int          ADDR_W     = 12,
   parameter logic [6:0]  ILLEGAL_OP = 7'd127
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [15:0]       i_pc_data,
   input  logic              i_halt,
   output logic              o_mem_r_en,
   output logic [ADDR_W-1:0] o_mem_r_addr,
   input  logic [7:0]        i_mem_r_data,
   output logic              o_valid,
   input  logic              i_ready,
   input  logic              i_exec_done,
   output logic [6:0]        o_decode,
   output logic [15:0]       o_opcode,
   output logic [3:0]        o_vx_addr,
   output logic [3:0]        o_vy_addr,
   output logic [7:0]        o_byte_kk,
   output logic [3:0]        o_nibble_n,
   output logic [11:0]       o_mem_addr
);

   state_t            state, state_nx;
   logic [ADDR_W-1:0] pc_q;
   logic [7:0]        hi_q;
   logic [6:0]        dec_nx;
   logic              unused_pc;

   assign unused_pc = ^i_pc_data;

   opcode_decoder #(.ILLEGAL_OP(ILLEGAL_OP)) u_dec (
      .opcode ({hi_q, i_mem_r_data}),
      .decode (dec_nx)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         pc_q     <= '0;
         hi_q     <= '0;
         o_decode <= '0;
         o_opcode <= '0;
      end else begin
         state <= state_nx;
         if (state == RD_HI) pc_q <= i_pc_data[ADDR_W-1:0];
         if (state == RD_LO) hi_q <= i_mem_r_data;
         if (state == CAPTURE) begin
            o_decode <= dec_nx;
            o_opcode <= {hi_q, i_mem_r_data};
         end
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:      state_nx = i_halt ? IDLE : RD_HI;
         RD_HI:     state_nx = RD_LO;
         RD_LO:     state_nx = CAPTURE;
         CAPTURE:   state_nx = ISSUE;
         ISSUE:     state_nx = !i_ready ? ISSUE : i_exec_done ? RD_HI : WAIT_EXEC;
         WAIT_EXEC: state_nx = !i_exec_done ? WAIT_EXEC : i_halt ? IDLE : RD_HI;
         default:   state_nx = IDLE;
      endcase
   end

   // Second byte address wraps within the program space.
   assign o_mem_r_en   = state == RD_HI || state == RD_LO;
   assign o_mem_r_addr = state == RD_HI ? i_pc_data[ADDR_W-1:0] : state == RD_LO ? pc_q + ADDR_W'(1) : '0;
   assign o_valid      = state == ISSUE;
   assign o_vx_addr    = o_opcode[11:8];
   assign o_vy_addr    = o_opcode[7:4];
   assign o_byte_kk    = o_opcode[7:0];
   assign o_nibble_n   = o_opcode[3:0];
   assign o_mem_addr   = o_opcode[11:0];

endmodule
